aram_arbiter: RTL

Shares the single-port 64 KiB audio RAM between the SPC700 core, the S-DSP voice/echo engine and the host SPC-image loader. It sits between the SMP/DSP bus masters and the ARAM memory controller, which is a BSRAM/SDRAM wrapper with fixed read latency. One transaction is in flight at a time. A starvation guard keeps the SPC700 from being locked out by heavy DSP traffic.

---
 rtl/smp_pkg.sv | 19 +
 rtl/aram_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/smp_pkg.sv
// Shared types for the audio-RAM arbiter: FSM states, bus owners and address width.
package smp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } aram_state_t;

    typedef enum logic [1:0] {
        OWN_SMP,
        OWN_DSP,
        OWN_LD
    } aram_owner_t;

    localparam int ARAM_AW = 16;

endpackage

// File: rtl/aram_arbiter.sv
// Single-port audio RAM arbiter for SPC700, S-DSP and host loader; one access in flight.
//
// state | meaning
// IDLE  | pick a winner among pending requests
// ISSUE | one-cycle MEM_REQ with the latched owner access
// WAIT  | count down the memory read latency, capture read data
// DONE  | one-cycle ACK to the owner, requests ignored
module aram_arbiter
    import smp_pkg::*;
#(
    parameter int         MEM_LAT    = 2,
    parameter logic [7:0] STARVE_MAX = 8'd16
) (
    input  logic               CLK,
    input  logic               RST_N,

    input  logic               SMP_REQ,
    input  logic [ARAM_AW-1:0] SMP_A,
    input  logic               SMP_WE_N,
    input  logic [7:0]         SMP_DO,
    output logic [7:0]         SMP_DI,
    output logic               SMP_ACK,
    input  logic               RAM_WRITE_EN,

    input  logic               DSP_REQ,
    input  logic [ARAM_AW-1:0] DSP_A,
    input  logic               DSP_WE_N,
    input  logic [7:0]         DSP_DO,
    output logic [7:0]         DSP_DI,
    output logic               DSP_ACK,

    input  logic               LD_EN,
    input  logic               LD_REQ,
    input  logic [ARAM_AW-1:0] LD_A,
    input  logic [7:0]         LD_DO,
    output logic               LD_ACK,

    output logic [ARAM_AW-1:0] MEM_A,
    output logic [7:0]         MEM_DO,
    output logic               MEM_WE_N,
    output logic               MEM_REQ,
    input  logic [7:0]         MEM_DI
);

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    aram_state_t        state;
    aram_owner_t        owner;
    logic [2:0]         lat_cnt;
    logic               cap_rd;
    logic [7:0]         starve_cnt;

    logic               smp_eff;
    logic               smp_starved;
    logic               smp_owns;
    logic               grant_any;
    aram_owner_t        win;
    logic [ARAM_AW-1:0] win_a;
    logic [7:0]         win_do;
    logic               win_we_n;
    logic               win_rd;

    always_comb begin
        smp_eff     = SMP_REQ & ~LD_EN;
        smp_starved = smp_eff && (starve_cnt == STARVE_MAX);
        smp_owns    = (state != IDLE) && (owner == OWN_SMP);
        grant_any   = 1'b1;
        win         = OWN_DSP;
        win_a       = DSP_A;
        win_do      = DSP_DO;
        win_we_n    = DSP_WE_N;
        win_rd      = DSP_WE_N;
        if (smp_starved || (!DSP_REQ && smp_eff)) begin
            win      = OWN_SMP;
            win_a    = SMP_A;
            win_do   = SMP_DO;
            // write-protected SMP writes become dummy reads, but never update SMP_DI
            win_we_n = SMP_WE_N | ~RAM_WRITE_EN;
            win_rd   = SMP_WE_N;
        end else if (DSP_REQ) begin
            win = OWN_DSP;
        end else if (LD_EN && LD_REQ) begin
            win      = OWN_LD;
            win_a    = LD_A;
            win_do   = LD_DO;
            win_we_n = 1'b0;
            win_rd   = 1'b0;
        end else begin
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            owner      <= OWN_SMP;
            lat_cnt    <= '0;
            cap_rd     <= 1'b0;
            starve_cnt <= '0;
            MEM_A      <= '0;
            MEM_DO     <= '0;
            MEM_WE_N   <= 1'b1;
            MEM_REQ    <= 1'b0;
            SMP_DI     <= '0;
            DSP_DI     <= '0;
            SMP_ACK    <= 1'b0;
            DSP_ACK    <= 1'b0;
            LD_ACK     <= 1'b0;
        end else begin
            MEM_REQ <= 1'b0;
            SMP_ACK <= 1'b0;
            DSP_ACK <= 1'b0;
            LD_ACK  <= 1'b0;

            if (!SMP_REQ) begin
                starve_cnt <= '0;
            end else if (state == IDLE && grant_any && win == OWN_SMP) begin
                starve_cnt <= '0;
            end else if (!smp_owns && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner    <= win;
                        MEM_A    <= win_a;
                        MEM_DO   <= win_do;
                        MEM_WE_N <= win_we_n;
                        cap_rd   <= win_rd;
                        MEM_REQ  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        case (owner)
                            OWN_SMP: begin
                                if (cap_rd) SMP_DI <= MEM_DI;
                                SMP_ACK <= 1'b1;
                            end
                            OWN_DSP: begin
                                if (cap_rd) DSP_DI <= MEM_DI;
                                DSP_ACK <= 1'b1;
                            end
                            default: LD_ACK <= 1'b1;
                        endcase
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
